// File: rtl/ysyx_22040125_hz_pkg.sv
// Shared types and constants for the hazard scoreboard: stage records,
// stage indices and the regfile bypass select.
package ysyx_22040125_hz_pkg;

  // Record rd field is wide enough for any supported register index width.
  localparam int unsigned REC_AW  = 8;

  localparam int unsigned STG_EX  = 1;
  localparam int unsigned STG_MEM = 2;
  localparam int unsigned STG_WB  = 3;

  // Bit 0 of every per-source select means "take the register file".
  localparam logic [31:0] FWD_RF  = 32'd1;

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic              load;
    logic              mdu;
    logic [REC_AW-1:0] rd;
  } stage_rec_t;

endpackage

// File: rtl/ysyx_22040125_hz_match.sv
// One source operand against all tracked stage records: one-hot bypass
// select (youngest match wins) and a flag when that result is not yet usable.
module ysyx_22040125_hz_match
  import ysyx_22040125_hz_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NSTG     = 3,
  parameter int unsigned LOAD_RDY = 2
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              used_i,
  input  stage_rec_t        rec_i [1:NSTG],
  input  logic              mdu_busy_i,
  output logic [NSTG:0]     sel_c,
  output logic              pend_c
);

  logic found;

  // Scan from EX outward so the youngest producer takes priority.
  always_comb begin
    sel_c  = (NSTG+1)'(FWD_RF);
    pend_c = 1'b0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NSTG; k++) begin
      if (!found && used_i && (rs_i != '0) && rec_i[k].valid && rec_i[k].wen &&
          (rec_i[k].rd == REC_AW'(rs_i))) begin
        found  = 1'b1;
        sel_c  = (NSTG+1)'(1) << k;
        pend_c = (rec_i[k].load && (k < LOAD_RDY)) || ((k == STG_EX) && mdu_busy_i);
      end
    end
  end

endmodule

// File: rtl/ysyx_22040125_hazard_sb.sv
// Hazard/forwarding scoreboard beside ID: shadows rd records for EX..WB and
// derives bypass selects, load-use / MDU stalls and the IF/ID flush.
module ysyx_22040125_hazard_sb
  import ysyx_22040125_hz_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned NSTG     = 3,
  parameter int unsigned LOAD_RDY = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic                        id_wen,
  input  logic                        id_load,
  input  logic                        id_mdu,
  input  logic                        mdu_done,
  input  logic                        redirect,
  output logic                        stall_id,
  output logic                        bubble_ex,
  output logic                        ex_hold,
  output logic                        flush_if_id,
  output logic [NUM_SRC*(NSTG+1)-1:0] fwd_sel,
  output logic                        mdu_busy,
  output logic [CNT_W-1:0]            stall_cycles
);

  stage_rec_t         rec_q [1:NSTG];
  stage_rec_t         rec_d [1:NSTG];
  stage_rec_t         id_rec;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;
  logic [NUM_SRC-1:0] pend;
  logic               hazard;
  logic               accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ysyx_22040125_hz_match #(
      .REG_AW   (REG_AW),
      .NSTG     (NSTG),
      .LOAD_RDY (LOAD_RDY)
    ) u_match (
      .rs_i       (id_rs[i*REG_AW +: REG_AW]),
      .used_i     (id_rs_used[i]),
      .rec_i      (rec_q),
      .mdu_busy_i (mdu_busy),
      .sel_c      (fwd_sel[i*(NSTG+1) +: (NSTG+1)]),
      .pend_c     (pend[i])
    );
  end

  assign mdu_busy     = rec_q[STG_EX].valid & rec_q[STG_EX].mdu & ~mdu_done;
  assign stall_cycles = stall_cnt_q;

  // Stall/flush controls; a redirect squashes ID so it never stalls.
  always_comb begin
    hazard      = id_valid & (|pend);
    ex_hold     = mdu_busy;
    stall_id    = ~redirect & (hazard | mdu_busy);
    bubble_ex   = ~redirect & hazard & ~mdu_busy;
    flush_if_id = redirect;
    accept      = id_valid & ~stall_id & ~redirect & ~ex_hold;
  end

  // Next-state of the shadow pipeline and the saturating stall counter.
  always_comb begin
    id_rec       = '{valid: 1'b1, wen: id_wen, load: id_load, mdu: id_mdu,
                     rd: REC_AW'(id_rd)};
    rec_d[STG_EX] = ex_hold ? rec_q[STG_EX] : (accept ? id_rec : '0);
    for (int unsigned k = 2; k <= NSTG; k++) begin
      rec_d[k] = ((k == 2) && ex_hold) ? '0 : rec_q[k-1];
    end
    stall_cnt_d = stall_cnt_q;
    if (stall_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 1; k <= NSTG; k++) begin
        rec_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      rec_q       <= rec_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_hazard_sb.sv
// Self-checking bench for the hazard scoreboard: per-scenario tasks push
// expected outputs to a queue and compare them each cycle.
module tb_ysyx_22040125_hazard_sb;
  import ysyx_22040125_hz_pkg::*;

  localparam logic [3:0] F_RF  = 4'b0001;
  localparam logic [3:0] F_EX  = 4'(1 << STG_EX);
  localparam logic [3:0] F_MEM = 4'(1 << STG_MEM);
  localparam logic [3:0] F_WB  = 4'(1 << STG_WB);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [1:0]  id_rs_used = '0;
  logic [4:0]  id_rd = '0;
  logic        id_wen = 1'b0;
  logic        id_load = 1'b0;
  logic        id_mdu = 1'b0;
  logic        mdu_done = 1'b0;
  logic        redirect = 1'b0;
  logic        stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy;
  logic [7:0]  fwd_sel;
  logic [31:0] stall_cycles;
  logic        stall_id2, bubble_ex2, ex_hold2, flush_if_id2, mdu_busy2;
  logic [7:0]  fwd_sel2;
  logic [1:0]  stall_cycles2;

  typedef struct {
    logic [12:0] v;
    int unsigned sc;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned sc_exp = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ysyx_22040125_hazard_sb dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load), .id_mdu(id_mdu),
    .mdu_done(mdu_done), .redirect(redirect), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .ex_hold(ex_hold), .flush_if_id(flush_if_id), .fwd_sel(fwd_sel), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles)
  );

  // Narrow-counter copy to exercise saturation.
  ysyx_22040125_hazard_sb #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load), .id_mdu(id_mdu),
    .mdu_done(mdu_done), .redirect(redirect), .stall_id(stall_id2), .bubble_ex(bubble_ex2),
    .ex_hold(ex_hold2), .flush_if_id(flush_if_id2), .fwd_sel(fwd_sel2), .mdu_busy(mdu_busy2),
    .stall_cycles(stall_cycles2)
  );

  // Redirect while an MDU op is in flight is illegal.
  always @(negedge clk) begin
    if (!rst && redirect && mdu_busy) begin
      errors++;
      $display("FAIL redirect_with_mdu_busy: got redirect=1 mdu_busy=1, want not both");
    end
  end

  task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic mdu);
    id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used; id_rd = rd;
    id_wen = wen; id_load = ld; id_mdu = mdu; mdu_done = 1'b0; redirect = 1'b0;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sc_exp = 0;
  endtask

  task automatic push_exp(input string name, input logic st, input logic bu, input logic ho,
                          input logic fl, input logic mb, input logic [3:0] f0,
                          input logic [3:0] f1);
    exp_t e;
    e.v = {st, bu, ho, fl, mb, f1, f0};
    e.sc = sc_exp;
    e.name = name;
    exp_q.push_back(e);
    if (st) sc_exp++;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      case (s)
        0: begin do_reset(); push_exp("reset_idle", 0, 0, 0, 0, 0, F_RF, F_RF); end
        default: begin redirect = 1'b1; push_exp("reset_redirect", 0, 0, 0, 1, 0, F_RF, F_RF); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel} !== e.v ||
          stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s: got %b cnt %0d, want %b cnt %0d", e.name,
                 {stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel},
                 stall_cycles, e.v, e.sc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_fwd();
    exp_t e;
    for (int s = 0; s < 12; s++) begin
      case (s)
        0, 2, 5, 9: begin
          do_reset();
          set_id(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 0);
          push_exp("alu_prod", 0, 0, 0, 0, 0, F_RF, F_RF);
        end
        1: begin set_id(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0); push_exp("alu_ex", 0, 0, 0, 0, 0, F_EX, F_EX); end
        3, 6, 7: begin
          set_id(1, 5'd1, 5'd2, 2'b11, 5'd10 + 5'(s), 1, 0, 0);
          push_exp("alu_unrelated", 0, 0, 0, 0, 0, F_RF, F_RF);
        end
        4: begin set_id(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0); push_exp("alu_mem", 0, 0, 0, 0, 0, F_MEM, F_MEM); end
        8: begin set_id(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0); push_exp("alu_wb", 0, 0, 0, 0, 0, F_WB, F_WB); end
        10: begin set_id(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 0); push_exp("alu_prod2", 0, 0, 0, 0, 0, F_RF, F_RF); end
        default: begin set_id(1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 0, 0); push_exp("alu_youngest", 0, 0, 0, 0, 0, F_EX, F_RF); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel} !== e.v ||
          stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s: got %b cnt %0d, want %b cnt %0d", e.name,
                 {stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel},
                 stall_cycles, e.v, e.sc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0, 6: begin
          do_reset();
          set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0);
          push_exp("ld_issue", 0, 0, 0, 0, 0, F_RF, F_RF);
        end
        1: begin set_id(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0); push_exp("lu_stall", 1, 1, 0, 0, 0, F_EX, F_RF); end
        2: begin set_id(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0); push_exp("lu_fwd_mem", 0, 0, 0, 0, 0, F_MEM, F_RF); end
        3: begin idle(); push_exp("lu_count", 0, 0, 0, 0, 0, F_RF, F_RF); end
        4: begin
          do_reset();
          set_id(1, 5'd1, 5'd0, 2'b01, 5'd0, 1, 1, 0);
          push_exp("ld_x0", 0, 0, 0, 0, 0, F_RF, F_RF);
        end
        5: begin set_id(1, 5'd0, 5'd0, 2'b11, 5'd12, 1, 0, 0); push_exp("r0_no_match", 0, 0, 0, 0, 0, F_RF, F_RF); end
        default: begin set_id(1, 5'd1, 5'd7, 2'b01, 5'd13, 1, 0, 0); push_exp("unused_src", 0, 0, 0, 0, 0, F_RF, F_RF); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel} !== e.v ||
          stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s: got %b cnt %0d, want %b cnt %0d", e.name,
                 {stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel},
                 stall_cycles, e.v, e.sc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mdu();
    exp_t e;
    for (int s = 0; s < 13; s++) begin
      if (s == 0) begin
        do_reset();
        set_id(1, 5'd1, 5'd2, 2'b11, 5'd9, 1, 0, 1);
        push_exp("div_issue", 0, 0, 0, 0, 0, F_RF, F_RF);
      end else if (s <= 10) begin
        set_id(1, 5'd9, 5'd3, 2'b11, 5'd11, 1, 0, 0);
        push_exp("mdu_wait", 1, 0, 1, 0, 1, F_EX, F_RF);
      end else if (s == 11) begin
        set_id(1, 5'd9, 5'd3, 2'b11, 5'd11, 1, 0, 0);
        mdu_done = 1'b1;
        push_exp("mdu_done_fwd", 0, 0, 0, 0, 0, F_EX, F_RF);
      end else begin
        idle();
        push_exp("mdu_after", 0, 0, 0, 0, 0, F_RF, F_RF);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel} !== e.v ||
          stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s: got %b cnt %0d, want %b cnt %0d", e.name,
                 {stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel},
                 stall_cycles, e.v, e.sc);
      end
      if (s == 12) begin
        checks++;
        if ({stall_id2, bubble_ex2, ex_hold2, flush_if_id2, mdu_busy2, fwd_sel2} !== e.v ||
            stall_cycles2 !== 2'b11) begin
          errors++;
          $display("FAIL cnt_saturate: got %b cnt %0d, want %b cnt 3",
                   {stall_id2, bubble_ex2, ex_hold2, flush_if_id2, mdu_busy2, fwd_sel2},
                   stall_cycles2, e.v);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin
          do_reset();
          set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0);
          push_exp("rd_ld_issue", 0, 0, 0, 0, 0, F_RF, F_RF);
        end
        1: begin
          set_id(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0);
          redirect = 1'b1;
          push_exp("redirect_squash", 0, 0, 0, 1, 0, F_EX, F_RF);
        end
        default: begin
          set_id(1, 5'd8, 5'd7, 2'b11, 5'd14, 1, 0, 0);
          push_exp("redirect_bubble", 0, 0, 0, 0, 0, F_RF, F_MEM);
        end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel} !== e.v ||
          stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s: got %b cnt %0d, want %b cnt %0d", e.name,
                 {stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel},
                 stall_cycles, e.v, e.sc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      if (s == 0) begin
        do_reset();
        set_id(1, 5'd1, 5'd2, 2'b11, 5'd9, 1, 0, 1);
        push_exp("rm_div_issue", 0, 0, 0, 0, 0, F_RF, F_RF);
      end else if (s <= 4) begin
        set_id(1, 5'd9, 5'd3, 2'b11, 5'd11, 1, 0, 0);
        if (s == 4) rst = 1'b1;
        push_exp("rm_wait", 1, 0, 1, 0, 1, F_EX, F_RF);
      end else begin
        rst = 1'b0;
        sc_exp = 0;
        set_id(1, 5'd9, 5'd3, 2'b11, 5'd11, 1, 0, 0);
        push_exp("rm_after_reset", 0, 0, 0, 0, 0, F_RF, F_RF);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel} !== e.v ||
          stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s: got %b cnt %0d, want %b cnt %0d", e.name,
                 {stall_id, bubble_ex, ex_hold, flush_if_id, mdu_busy, fwd_sel},
                 stall_cycles, e.v, e.sc);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_mdu();
    test_redirect();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040125_hazard_sb.md
Name: ysyx_22040125_hazard_sb

Overview:
- Parametrised successor to the pipeline hazard/forwarding controller for the RV64 in-order core. It keeps its own shadow pipeline of destination-register records for EX..WB, so the datapath no longer feeds per-stage rd/wen/ren back in.
- It produces per-source one-hot bypass selects, load-use and multi-cycle (MUL/DIV) stalls, and the IF/ID flush.
- It sits beside the ID stage and drives the IF/ID hold, ID/EX bubble and EX hold controls.

Parameters:
- REG_AW, 5, register index width; r0 is hardwired zero.
- NUM_SRC, 2, source operands checked per ID instruction.
- NSTG, 3, tracked stages after ID; stage 1 = EX … stage NSTG = WB.
- LOAD_RDY, 2, first stage index whose load result is bypassable; must satisfy 1 ≤ LOAD_RDY ≤ NSTG.
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*REG_AW  source indices; src i at [i*REG_AW +: REG_AW]
- id_rs_used  in  NUM_SRC  source i is actually read
- id_rd  in  REG_AW  destination index
- id_wen  in  1  ID instruction writes rd
- id_load  in  1  ID instruction is a load
- id_mdu  in  1  ID instruction is a multi-cycle MUL/DIV
- mdu_done  in  1  MDU result valid this cycle (EX)
- redirect  in  1  EX resolved a taken branch/jump
- stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load a NOP into ID/EX
- ex_hold  out  1  freeze EX and ID/EX (MDU in flight)
- flush_if_id  out  1  squash IF/ID
- fwd_sel  out  NUM_SRC*(NSTG+1)  one-hot per src; bit0 = regfile, bit k = stage k result
- mdu_busy  out  1  MDU op resident in EX, not yet done
- stall_cycles  out  CNT_W  saturating count of cycles with stall_id=1

Behaviour:
- Stage record fields: {valid, wen, load, mdu, rd}. Records are registered; all outputs are combinational from the records plus inputs.
- Reset (synchronous): every record valid=0, mdu_busy=0, stall_cycles=0. With empty records the outputs are: stall_id=0, bubble_ex=0, ex_hold=0, flush_if_id=redirect, and every fwd_sel = …0001.
- Match rule: stage k matches src i when all hold:
  - id_rs_used[i]
  - id_rs[i] != 0
  - rec[k].valid, rec[k].wen
  - rec[k].rd == id_rs[i]
- Forwarding priority: the youngest matching stage (lowest k) wins. No match selects bit0.
- Pending results:
  - A winning match whose record is a load with k < LOAD_RDY is a load-use hazard.
  - A winning match at k=1 while mdu_busy is an MDU-use hazard.
  - In both cases fwd_sel still shows that stage, but the value is invalid.
- mdu_busy = rec[1].valid & rec[1].mdu & !mdu_done; ex_hold = mdu_busy.
- hazard = id_valid & (load-use | MDU-use).
- stall_id = !redirect & (hazard | mdu_busy).
- bubble_ex = !redirect & hazard & !mdu_busy.
- flush_if_id = redirect.
- Record advance each cycle:
  - ex_hold=1: rec[1] holds; rec[k>1] shift (rec[2] receives a bubble); ID is not accepted.
  - Otherwise rec[k] <= rec[k-1] for k ≥ 2.
  - rec[1] <= ID record when id_valid & !stall_id & !redirect; else it becomes a bubble.
- Redirect:
  - The instruction in ID is squashed: not entered, and it produces no stall.
  - Older stages are unaffected.
  - redirect together with mdu_busy is illegal; the bench asserts on it.
- mdu_done in the same cycle as the ID consumer of that rd: mdu_busy=0, so k=1 is bypassable that cycle and there is no stall.
- A load at k ≥ LOAD_RDY forwards normally.
- An ID instruction with rd=0 is still recorded, but it never matches.
- stall_cycles increments by 1 when stall_id=1 and holds at all-ones.

Decomposition:
- Package ysyx_22040125_hz_pkg holds:
  - the stage-record struct;
  - the FWD_RF one-hot constant;
  - localparams for the stage indices EX=1, MEM=2, WB=3.
- One sub-module, ysyx_22040125_hz_match: for one source against all NSTG records it outputs the one-hot select and a pending flag. It is instantiated NUM_SRC times via generate.

Test Plan:
- ALU dependency: add x5 then add x6,x5,x5 back-to-back → fwd_sel src0 = src1 = 4'b0010, no stall. With one unrelated instruction between them → 4'b0100; with two between → 4'b1000.
- Load-use: ld x7 then add x8,x7,x1 → exactly 1 cycle of stall_id=1 and bubble_ex=1. The next cycle fwd_sel src0 = 4'b0100; stall_cycles = 1.
- MDU: div x9 issued, mdu_done pulsed 10 cycles later, consumer of x9 waiting in ID:
  - stall_id=1 and ex_hold=1 for all 10 cycles;
  - in the mdu_done cycle fwd_sel = 4'b0010 with stall_id=0.
- Redirect with a load-use pair in ID: redirect=1 → flush_if_id=1, stall_id=0, and rec[1] becomes a bubble next cycle.
- r0 and unused sources: ld x0 followed by a reader of x0 → no stall, fwd_sel = 4'b0001. A source with id_rs_used=0 that matches a load → no stall.
- Reset mid-operation: assert rst during an MDU stall → next cycle mdu_busy=0, stall_id=0, all fwd_sel = 4'b0001, stall_cycles=0.
